// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR-latch driver: FSM encoding, synchroniser depth
// and the feedback comparison used when a command completes.
package sr_drv_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } drv_state_e;

    // True when the synchronised latch outputs disagree with the commanded value.
    function automatic logic fb_mismatch(
        input logic exp_q,
        input logic q_sync,
        input logic qbar_sync
    );
        return (q_sync != exp_q) || (qbar_sync != ~exp_q);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command/status handshake between a requester and the SR-latch driver.
interface sr_latch_driver_if;
    import sr_drv_pkg::*;

    logic req_valid;
    logic req_set;
    logic ready;
    logic done;
    logic err;
    logic expected_q;

    modport master (
        output req_valid,
        output req_set,
        input  ready,
        input  done,
        input  err,
        input  expected_q
    );

    modport slave (
        input  req_valid,
        input  req_set,
        output ready,
        output done,
        output err,
        output expected_q
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, two bits wide, for the asynchronous latch feedback.
module sync_2ff
    import sr_drv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= {stage_q[SYNC_STAGES-2:0], din[gi]};
                end
            end

            assign dout[gi] = stage_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a NAND SR latch with one fixed-width active-low pulse per accepted
// command, then checks the synchronised q/qbar against the commanded value.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 4
) (
    input  logic              clk,
    input  logic              reset,
    sr_latch_driver_if.slave  cmd,
    output logic              sbar,
    output logic              rbar,
    input  logic              q_fb,
    input  logic              qbar_fb
);

    localparam longint CNT_MAX     = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (PULSE_CYCLES < 1) begin : g_bad_pulse
            $error("sr_latch_driver: PULSE_CYCLES must be at least 1");
        end
        if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
            $error("sr_latch_driver: SETTLE_CYCLES must cover the feedback synchroniser");
        end
        if ((longint'(PULSE_CYCLES) - 1 > CNT_MAX) ||
            (longint'(SETTLE_CYCLES) - 1 > CNT_MAX)) begin : g_bad_cnt
            $error("sr_latch_driver: CNT_W too narrow for the pulse/settle counts");
        end
    endgenerate

    drv_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sbar_q, sbar_d;
    logic             rbar_q, rbar_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             exp_q, exp_d;
    logic [1:0]       fb_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({q_fb, qbar_fb}),
        .dout  (fb_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sbar_q  <= 1'b1;
            rbar_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sbar_q  <= sbar_d;
            rbar_q  <= rbar_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            exp_q   <= exp_d;
        end
    end

    // Line values are computed for the state being entered, so the registered
    // outputs line up with the state register. The pulse drives sbar/rbar as
    // complements, which makes the both-low combination unreachable.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sbar_d  = 1'b1;
        rbar_d  = 1'b1;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        exp_d   = exp_q;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cmd.req_valid) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    exp_d   = cmd.req_set;
                    sbar_d  = ~cmd.req_set;
                    rbar_d  = cmd.req_set;
                    ready_d = 1'b0;
                end
            end

            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    sbar_d = ~exp_q;
                    rbar_d = exp_q;
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = fb_mismatch(exp_q, fb_sync[1], fb_sync[0]);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ready_d = 1'b1;
            end
        endcase
    end

    assign sbar           = sbar_q;
    assign rbar           = rbar_q;
    assign cmd.ready      = ready_q;
    assign cmd.done       = done_q;
    assign cmd.err        = err_q;
    assign cmd.expected_q = exp_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench: drives sr_latch_driver against a behavioural NAND SR latch.
module tb_sr_latch_driver;

    logic clk;
    logic reset;
    logic sbar;
    logic rbar;
    logic q_fb;
    logic qbar_fb;
    logic latch_q;
    logic fb_fault;
    logic mon_en;
    int   total;
    int   bad;
    int   inv_viol;

    sr_latch_driver_if cmd_if ();

    sr_latch_driver #(
        .PULSE_CYCLES  (2),
        .SETTLE_CYCLES (3),
        .CNT_W         (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd_if),
        .sbar    (sbar),
        .rbar    (rbar),
        .q_fb    (q_fb),
        .qbar_fb (qbar_fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // NAND latch: low sbar sets, low rbar resets, both high holds.
    initial latch_q = 1'b0;
    always @(sbar or rbar) begin
        if (!sbar && rbar)
            latch_q = 1'b1;
        else if (sbar && !rbar)
            latch_q = 1'b0;
    end

    assign q_fb    = fb_fault ? 1'b0 : latch_q;
    assign qbar_fb = fb_fault ? 1'b1 : ~latch_q;

    always @(negedge clk) begin
        if (mon_en && !sbar && !rbar)
            inv_viol = inv_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and measure the pulse and completion timing.
    task automatic run_cmd(input string name, input logic s, input logic exp_err);
        int low_cnt;
        int other_bad;
        int done_at;
        logic first_low;
        low_cnt   = 0;
        other_bad = 0;
        done_at   = -1;
        chk({name, "_ready_before"}, cmd_if.ready, 1'b1);
        cmd_if.req_valid = 1'b1;
        cmd_if.req_set   = s;
        step();
        cmd_if.req_valid = 1'b0;
        first_low = s ? sbar : rbar;
        chk({name, "_first_low"}, first_low, 1'b0);
        for (int c = 0; c < 20 && done_at < 0; c++) begin
            if ((s ? sbar : rbar) == 1'b0) low_cnt++;
            if ((s ? rbar : sbar) == 1'b0) other_bad++;
            if (cmd_if.done) done_at = c;
            else step();
        end
        chk({name, "_pulse_len"}, low_cnt, 2);
        chk({name, "_other_high"}, other_bad, 0);
        chk({name, "_done_at"}, done_at, 5);
        chk({name, "_err"}, cmd_if.err, exp_err);
        chk({name, "_expected_q"}, cmd_if.expected_q, s);
        chk({name, "_latch_q"}, latch_q, s);
        step();
        chk({name, "_done_one_cycle"}, cmd_if.done, 1'b0);
        chk({name, "_ready_after"}, cmd_if.ready, 1'b1);
        $display("cmd %s set=%0b done_at=%0d pulse=%0d err=%0b", name, s, done_at, low_cnt, cmd_if.err);
    endtask

    initial begin
        int last_acc;
        int acc_cnt;
        int spacing_bad;
        int done_seen;
        int waited;
        logic prev_acc;
        logic prev_set;

        total    = 0;
        bad      = 0;
        inv_viol = 0;
        mon_en   = 1'b0;
        fb_fault = 1'b0;
        cmd_if.req_valid = 1'b0;
        cmd_if.req_set   = 1'b0;

        // 1. Post-reset state
        reset = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        chk("rst_sbar", sbar, 1'b1);
        chk("rst_rbar", rbar, 1'b1);
        chk("rst_ready", cmd_if.ready, 1'b1);
        chk("rst_done", cmd_if.done, 1'b0);
        chk("rst_err", cmd_if.err, 1'b0);
        chk("rst_expq", cmd_if.expected_q, 1'b0);
        $display("reset: sbar=%0b rbar=%0b ready=%0b", sbar, rbar, cmd_if.ready);
        reset = 1'b0;
        step();

        // 2./3. Set then reset
        run_cmd("set", 1'b1, 1'b0);
        run_cmd("clr", 1'b0, 1'b0);

        // 4. Feedback fault, sticky err, then recovery
        fb_fault = 1'b1;
        run_cmd("fault_set", 1'b1, 1'b1);
        step();
        step();
        chk("err_sticky", cmd_if.err, 1'b1);
        fb_fault = 1'b0;
        step();
        run_cmd("recover_clr", 1'b0, 1'b0);

        // 5. Back-to-back requests with req_set toggling every cycle
        last_acc    = -1;
        acc_cnt     = 0;
        spacing_bad = 0;
        prev_acc    = 1'b0;
        prev_set    = 1'b0;
        cmd_if.req_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cmd_if.req_set = i[0];
            if (prev_acc)
                chk("b2b_expq", cmd_if.expected_q, prev_set);
            prev_acc = cmd_if.ready;
            prev_set = i[0];
            if (cmd_if.ready) begin
                if (last_acc >= 0 && (i - last_acc) != 7) spacing_bad++;
                last_acc = i;
                acc_cnt++;
                $display("b2b accept cycle=%0d set=%0b", i, i[0]);
            end
            step();
        end
        cmd_if.req_valid = 1'b0;
        chk("b2b_accepts", acc_cnt, 6);
        chk("b2b_spacing", spacing_bad, 0);
        waited = 0;
        while (!cmd_if.ready && waited < 20) begin
            step();
            waited++;
        end
        chk("b2b_drain", cmd_if.ready, 1'b1);

        // 6. Reset during the first low cycle of a set pulse
        cmd_if.req_valid = 1'b1;
        cmd_if.req_set   = 1'b1;
        step();
        cmd_if.req_valid = 1'b0;
        chk("midrst_pulse_low", sbar, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_sbar", sbar, 1'b1);
        chk("midrst_rbar", rbar, 1'b1);
        chk("midrst_ready", cmd_if.ready, 1'b1);
        chk("midrst_expq", cmd_if.expected_q, 1'b0);
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (cmd_if.done) done_seen++;
            step();
        end
        chk("midrst_no_done", done_seen, 0);
        $display("midrst: sbar=%0b rbar=%0b done_seen=%0d", sbar, rbar, done_seen);

        chk("invariant", inv_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous initiator that drives a NAND-based SR latch through its active-low set/reset inputs (sbar, rbar).
- Accepts one set/reset command per valid/ready handshake and generates a clean, fixed-width low pulse on exactly one of sbar/rbar.
- Never drives the forbidden both-low condition.
- Reads the latch's q/qbar back through a 2-flop synchroniser and reports whether the latch reached the commanded state.

Parameters:
- PULSE_CYCLES, 2, number of cycles the selected sbar/rbar line is held low; legal range >= 1.
- SETTLE_CYCLES, 3, cycles both lines are held high after the pulse before feedback is checked; legal range >= SYNC_STAGES+1.
- CNT_W, 4, width of the internal pulse/settle counter; must hold max(PULSE_CYCLES, SETTLE_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  command present.
- req_set  input  1  1 = set latch (pulse sbar), 0 = reset latch (pulse rbar); sampled on accept only.
- ready  output  1  driver idle, able to accept a command.
- sbar  output  1  active-low set to latch; registered; idle 1.
- rbar  output  1  active-low reset to latch; registered; idle 1.
- q_fb  input  1  latch q, asynchronous to clk.
- qbar_fb  input  1  latch qbar, asynchronous to clk.
- done  output  1  one-cycle pulse: command complete, err valid.
- err  output  1  1 = synchronised feedback did not match the command (q_fb != expected or qbar_fb != ~expected); held until the next done.
- expected_q  output  1  last commanded latch value.

Behaviour:
- Reset values: sbar=1, rbar=1, ready=1, done=0, err=0, expected_q=0, state=IDLE, counter=0, synchroniser flops=0.
- States: IDLE, PULSE, SETTLE, DONE.
- IDLE:
  - ready=1.
  - On an edge with req_valid=1 (accept): go to PULSE, capture req_set into expected_q, load counter.
  - From the next cycle, drive sbar=0 if req_set=1, otherwise rbar=0.
- PULSE:
  - The selected line is low for exactly PULSE_CYCLES consecutive cycles; the other line stays 1.
  - Then go to SETTLE.
- SETTLE:
  - sbar=rbar=1 for exactly SETTLE_CYCLES cycles, then go to DONE.
- DONE (one cycle):
  - done=1.
  - err is computed from the synchronised q/qbar sampled on the edge that enters DONE.
  - Next edge: IDLE.
- ready=0 in PULSE, SETTLE and DONE. req_valid is ignored while ready=0; the command is not queued.
- Latency: first low cycle is the cycle after accept; done is asserted PULSE_CYCLES+SETTLE_CYCLES cycles after the first low cycle; ready returns the cycle after done.
- Invariant, every cycle including the reset cycle: !(sbar==0 && rbar==0).
- Redundant commands (set while expected_q=1) are executed normally; a pulse is still issued.
- Feedback path:
  - q_fb and qbar_fb each pass through SYNC_STAGES=2 flops before use.
  - Raw inputs are never used in logic.
- err is sticky between completions. It is overwritten only at done and cleared only by reset.
- Reset mid-operation (any state): at the reset edge, sbar=rbar=1 and ready=1; no done is issued; expected_q=0.
- Counter is CNT_W bits, loaded with N-1 and decremented to 0. It never wraps under legal parameters.
- Elaboration-time check: illegal parameters (PULSE_CYCLES<1, SETTLE_CYCLES<SYNC_STAGES+1, or counter overflow) stop elaboration with an error.

Decomposition:
- Shared package sr_drv_pkg: state encoding (IDLE=2'd0, PULSE=2'd1, SETTLE=2'd2, DONE=2'd3) and constant SYNC_STAGES=2.
- One sub-module: sync_2ff, a 2-bit wide two-flop synchroniser for {q_fb, qbar_fb} with synchronous active-high reset to 0.
- FSM, counter and output registers stay in sr_latch_driver.

Test Plan:
Benches instantiate the existing NAND sr_latch model with sbar/rbar driven by the DUT and q/qbar fed back. Defaults apply unless stated.
1. Post-reset: after 2 reset cycles -> sbar=1, rbar=1, ready=1, done=0, err=0, expected_q=0.
2. Set command (req_valid=1, req_set=1 for one cycle) -> sbar=0 for exactly 2 cycles, rbar=1 throughout; done high 5 cycles after the first low cycle; q=1, err=0, expected_q=1.
3. Reset command (req_set=0) after scenario 2 -> rbar=0 for exactly 2 cycles, sbar=1 throughout; done after 5 cycles; q=0, err=0, expected_q=0.
4. Fault: disconnect feedback (q_fb forced 0, qbar_fb forced 1), issue set -> done with err=1. err stays 1 until the next done. Restore feedback, issue reset -> err=0.
5. Back-to-back: hold req_valid=1 and toggle req_set every cycle for 40 cycles -> commands are accepted only while ready=1, the spacing between accepts is 7 cycles, and the invariant assertion never fires.
6. Reset mid-pulse: assert reset in the first sbar=0 cycle -> next edge sbar=1, rbar=1, ready=1, expected_q=0, and no done pulse occurs.
